// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the return-address stack: default
// address width and stack depth, the stored frame layout, and the
// operation encoding the stack control decodes each cycle.
package cpu_pkg;

   // Default PC width and number of return-stack entries
   localparam int CPU_AW    = 16;
   localparam int CPU_DEPTH = 16;

   // One stack frame: isInt marks a frame pushed on interrupt entry
   typedef struct packed {
      logic              isInt;
      logic [CPU_AW-1:0] addr;
   } entry_t;

   // Per-cycle stack operation after resolving the strobes
   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_REPL = 2'd3
   } op_e;

endpackage

// File: rtl/stack_mem.sv
// Register file backing the return stack: one synchronous write port
// and one asynchronous read port. Holds no control state of its own.
module stack_mem #(
   parameter int DEPTH = 16,
   parameter int W     = 17
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] memQ [DEPTH];

   // Store a frame on the clock edge when the stack control asks for it
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         memQ[waddr_i] <= wdata_i;
      end
   end

   // Combinational read so the control can refill the top register on a pop
   always_comb begin
      rdata_o = memQ[raddr_i];
   end

endmodule

// File: rtl/return_stack.sv
// Hardware return-address stack. Captures return addresses on call and
// interrupt entry, presents the top of stack from a dedicated register,
// and tracks how many interrupt frames are currently stacked.
module return_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = CPU_DEPTH,
   parameter int AW    = CPU_AW
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   Push,
   input  logic                   IntPush,
   input  logic                   Pop,
   input  logic [AW-1:0]          PCin,
   input  logic                   ClrErr,
   output logic [AW-1:0]          DoST,
   output logic [$clog2(DEPTH):0] Level,
   output logic                   Empty,
   output logic                   Full,
   output logic                   InISR,
   output logic                   Overflow,
   output logic                   Underflow
);

   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;

   logic [LW-1:0] levelQ, levelD;
   logic [LW-1:0] intCntQ, intCntD;
   entry_t        topQ, topD;
   logic          ovfQ, ovfD;
   logic          udfQ, udfD;

   entry_t        newEntry;
   entry_t        memRdata;
   op_e           op;
   logic          isEmpty;
   logic          isFull;
   logic          ovfEvt;
   logic          udfEvt;
   logic          memWe;
   logic [IW-1:0] memWaddr;
   logic [IW-1:0] memRaddr;

   // Build the frame to push (interrupt entry wins over call) and resolve the strobes into one op
   always_comb begin
      newEntry.isInt = IntPush;
      newEntry.addr  = IntPush ? PCin : PCin + AW'(1);
      isEmpty        = (levelQ == '0);
      isFull         = (levelQ == LW'(DEPTH));
      op             = OP_NONE;
      if ((Push | IntPush) & Pop) begin
         op = isEmpty ? OP_PUSH : OP_REPL;
      end else if (Push | IntPush) begin
         op = OP_PUSH;
      end else if (Pop) begin
         op = OP_POP;
      end
   end

   // Next-state logic for level, top register, interrupt count, error flags and memory write
   always_comb begin
      levelD   = levelQ;
      topD     = topQ;
      intCntD  = intCntQ;
      ovfEvt   = 1'b0;
      udfEvt   = 1'b0;
      memWe    = 1'b0;
      memWaddr = levelQ[IW-1:0];
      memRaddr = IW'(levelQ - LW'(2));
      case (op)
         OP_PUSH: begin
            if (isFull) begin
               ovfEvt = 1'b1;
            end else begin
               memWe   = 1'b1;
               levelD  = levelQ + LW'(1);
               topD    = newEntry;
               intCntD = intCntQ + LW'(newEntry.isInt);
            end
         end
         OP_POP: begin
            if (isEmpty) begin
               udfEvt = 1'b1;
            end else begin
               levelD  = levelQ - LW'(1);
               topD    = (levelQ == LW'(1)) ? '0 : memRdata;
               intCntD = intCntQ - LW'(topQ.isInt);
            end
         end
         OP_REPL: begin
            memWe    = 1'b1;
            memWaddr = IW'(levelQ - LW'(1));
            topD     = newEntry;
            intCntD  = intCntQ - LW'(topQ.isInt) + LW'(newEntry.isInt);
         end
         default: begin
         end
      endcase
      ovfD = (ovfQ & ~ClrErr) | ovfEvt;
      udfD = (udfQ & ~ClrErr) | udfEvt;
   end

   // Register all stack state; reset clears it and overrides any strobe in the same cycle
   always_ff @(posedge CLK) begin
      if (!RST) begin
         levelQ  <= '0;
         topQ    <= '0;
         intCntQ <= '0;
         ovfQ    <= 1'b0;
         udfQ    <= 1'b0;
      end else begin
         levelQ  <= levelD;
         topQ    <= topD;
         intCntQ <= intCntD;
         ovfQ    <= ovfD;
         udfQ    <= udfD;
      end
   end

   stack_mem #(
      .DEPTH (DEPTH),
      .W     (AW + 1)
   ) uStackMem (
      .clk_i   (CLK),
      .we_i    (memWe & RST),
      .waddr_i (memWaddr),
      .wdata_i (newEntry),
      .raddr_i (memRaddr),
      .rdata_o (memRdata)
   );

   // Drive the outputs straight from registered state
   always_comb begin
      DoST      = topQ.addr;
      Level     = levelQ;
      Empty     = isEmpty;
      Full      = isFull;
      InISR     = (intCntQ != '0);
      Overflow  = ovfQ;
      Underflow = udfQ;
   end

endmodule
